// File: rtl/adc_waveform_sequencer.sv
// ADC waveform sequencer: on a trigger, stores N waveforms of L samples each,
// separated by gaps timed by an external registered gap counter.
// Optional feature macro: ADC_SEQ_OVERRUN_CNT_EN adds the overrun_cnt port,
// a saturating count of triggers rejected while a burst is in progress.
module adc_waveform_sequencer #(
    parameter int unsigned LEN_W  = 12,
    parameter int unsigned NWFM_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic              abort,
    input  logic [LEN_W-1:0]  waveform_length,
    input  logic [NWFM_W-1:0] num_waveforms,
    input  logic              gap_at_zero,
    output logic              gap_init,
    output logic              gap_enable,
    output logic              wfm_write_en,
    output logic              wfm_start,
    output logic              wfm_last,
    output logic [NWFM_W-1:0] wfm_index,
    output logic              busy,
    output logic              done
`ifdef ADC_SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]        overrun_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACQ      = 3'd1,
        GAP_ARM  = 3'd2,
        GAP_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              arm_first, arm_first_nxt;
    logic [LEN_W-1:0]  len_m1, len_m1_nxt;
    logic [LEN_W-1:0]  sample_cnt, sample_cnt_nxt;
    logic [NWFM_W-1:0] nwfm_m1, nwfm_m1_nxt;
    logic [NWFM_W-1:0] index_nxt;
    logic              gap_init_nxt, gap_enable_nxt, write_en_nxt;
    logic              start_nxt, last_nxt, busy_nxt, done_nxt;

    // Next-state and next-output decode; outputs are registered from these
    always_comb begin
        state_nxt      = state;
        arm_first_nxt  = 1'b0;
        len_m1_nxt     = len_m1;
        nwfm_m1_nxt    = nwfm_m1;
        sample_cnt_nxt = sample_cnt;
        index_nxt      = wfm_index;
        start_nxt      = 1'b0;
        last_nxt       = 1'b0;
        gap_init_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    sample_cnt_nxt = '0;
                    index_nxt      = '0;
                    if (waveform_length == '0 || num_waveforms == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = ACQ;
                        len_m1_nxt  = waveform_length - LEN_W'(1);
                        nwfm_m1_nxt = num_waveforms - NWFM_W'(1);
                        start_nxt   = 1'b1;
                        last_nxt    = (waveform_length == LEN_W'(1));
                    end
                end
            end
            ACQ: begin
                if (sample_cnt == len_m1) begin
                    if (wfm_index == nwfm_m1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt     = GAP_ARM;
                        arm_first_nxt = 1'b1;
                        gap_init_nxt  = 1'b1;
                    end
                end else begin
                    sample_cnt_nxt = sample_cnt + LEN_W'(1);
                    last_nxt       = (sample_cnt_nxt == len_m1);
                end
            end
            GAP_ARM: begin
                // gap_at_zero still reflects the previous load here; wait it out
                if (!arm_first) begin
                    state_nxt = GAP_WAIT;
                end
            end
            GAP_WAIT: begin
                if (gap_at_zero) begin
                    state_nxt      = ACQ;
                    index_nxt      = wfm_index + NWFM_W'(1);
                    sample_cnt_nxt = '0;
                    start_nxt      = 1'b1;
                    last_nxt       = (len_m1 == '0);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything, including a trigger in the same cycle
        if (abort && state != IDLE) begin
            state_nxt     = IDLE;
            arm_first_nxt = 1'b0;
            start_nxt     = 1'b0;
            last_nxt      = 1'b0;
            gap_init_nxt  = 1'b0;
        end

        if (state_nxt == IDLE) begin
            index_nxt = '0;
        end

        write_en_nxt   = (state_nxt == ACQ);
        gap_enable_nxt = (state_nxt == GAP_ARM) || (state_nxt == GAP_WAIT);
        busy_nxt       = (state_nxt != IDLE);
        done_nxt       = (state_nxt == DONE);
    end

    // State, latched burst parameters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            arm_first    <= 1'b0;
            len_m1       <= '0;
            nwfm_m1      <= '0;
            sample_cnt   <= '0;
            wfm_index    <= '0;
            gap_init     <= 1'b0;
            gap_enable   <= 1'b0;
            wfm_write_en <= 1'b0;
            wfm_start    <= 1'b0;
            wfm_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            arm_first    <= arm_first_nxt;
            len_m1       <= len_m1_nxt;
            nwfm_m1      <= nwfm_m1_nxt;
            sample_cnt   <= sample_cnt_nxt;
            wfm_index    <= index_nxt;
            gap_init     <= gap_init_nxt;
            gap_enable   <= gap_enable_nxt;
            wfm_write_en <= write_en_nxt;
            wfm_start    <= start_nxt;
            wfm_last     <= last_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

`ifdef ADC_SEQ_OVERRUN_CNT_EN
    localparam int unsigned OVR_W = 8;

    logic [OVR_W-1:0] overrun_nxt;

    // Count triggers that arrive while a burst is active, saturating at max
    always_comb begin
        overrun_nxt = overrun_cnt;
        if (trigger && state != IDLE && overrun_cnt != {OVR_W{1'b1}}) begin
            overrun_nxt = overrun_cnt + OVR_W'(1);
        end
    end

    // Overrun counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= '0;
        end else begin
            overrun_cnt <= overrun_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_adc_waveform_sequencer.sv
// Bench for adc_waveform_sequencer: table of bursts checked against a
// queue-based expected timeline, plus trigger-overrun, abort and reset sequences.
// The overrun counter check is compiled in with ADC_SEQ_OVERRUN_CNT_EN.
module tb_adc_waveform_sequencer;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned NWFM_W = 8;
    localparam int unsigned MAXR   = 1024;

    typedef struct {
        int l;
        int n;
        int g;
        int exp_done;
        int exp_writes;
    } vec_t;

    typedef struct {
        int rel;
        bit st;
        bit la;
        int idx;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              trigger;
    logic              abort;
    logic [LEN_W-1:0]  waveform_length;
    logic [NWFM_W-1:0] num_waveforms;
    logic              gap_at_zero;
    logic              gap_init;
    logic              gap_enable;
    logic              wfm_write_en;
    logic              wfm_start;
    logic              wfm_last;
    logic [NWFM_W-1:0] wfm_index;
    logic              busy;
    logic              done;
`ifdef ADC_SEQ_OVERRUN_CNT_EN
    logic [7:0]        overrun_cnt;
`endif

    adc_waveform_sequencer #(.LEN_W(LEN_W), .NWFM_W(NWFM_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trigger         (trigger),
        .abort           (abort),
        .waveform_length (waveform_length),
        .num_waveforms   (num_waveforms),
        .gap_at_zero     (gap_at_zero),
        .gap_init        (gap_init),
        .gap_enable      (gap_enable),
        .wfm_write_en    (wfm_write_en),
        .wfm_start       (wfm_start),
        .wfm_last        (wfm_last),
        .wfm_index       (wfm_index),
        .busy            (busy),
        .done            (done)
`ifdef ADC_SEQ_OVERRUN_CNT_EN
        ,
        .overrun_cnt     (overrun_cnt)
`endif
    );

    int   cyc = 0;
    int   t0 = 0;
    bit   mon_on = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   gap_val = 0;
    int   obs_done_rel;
    int   obs_writes;
    int   mrel;
    wr_t  wq[$];
    int   gq[$];
    int   dq[$];
    bit   exp_busy[MAXR];
    bit   exp_ge[MAXR];
    logic [15:0] gcnt;
    logic        ginit_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream gap counter model: loads G on gap_init, holds one cycle,
    // then counts down while enabled; at_zero is registered from the count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt        <= 16'd0;
            ginit_q     <= 1'b0;
            gap_at_zero <= 1'b0;
        end else begin
            ginit_q <= gap_init;
            if (gap_init) gcnt <= 16'(gap_val);
            else if (gap_enable && !ginit_q && gcnt != 16'd0) gcnt <= gcnt - 16'd1;
            gap_at_zero <= (gcnt == 16'd0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle monitor: pops expected events as the DUT produces them
    always @(negedge clk) begin
        if (mon_on) begin
            mrel = cyc - t0;
            check($sformatf("flags@%0d", mrel),
                  64'({busy, gap_enable, wfm_start & ~wfm_write_en, wfm_last & ~wfm_write_en}),
                  64'({(mrel >= 0 && mrel < MAXR) ? exp_busy[mrel] : 1'b0,
                       (mrel >= 0 && mrel < MAXR) ? exp_ge[mrel] : 1'b0, 2'b00}));
            if (wfm_write_en) begin
                wr_t w;
                obs_writes++;
                if (wq.size() == 0) begin
                    check($sformatf("unexpected_write@%0d", mrel), 64'd1, 64'd0);
                end else begin
                    w = wq.pop_front();
                    check("write_cycle", 64'(mrel), 64'(w.rel));
                    check($sformatf("write_flags@%0d", mrel), 64'({wfm_start, wfm_last}), 64'({w.st, w.la}));
                    check($sformatf("write_index@%0d", mrel), 64'(wfm_index), 64'(w.idx));
                end
            end
            if (gap_init) begin
                if (gq.size() == 0) check($sformatf("unexpected_gap_init@%0d", mrel), 64'd1, 64'd0);
                else check("gap_init_cycle", 64'(mrel), 64'(gq.pop_front()));
            end
            if (done) begin
                obs_done_rel = mrel;
                if (dq.size() == 0) check($sformatf("unexpected_done@%0d", mrel), 64'd1, 64'd0);
                else check("done_cycle", 64'(mrel), 64'(dq.pop_front()));
            end
        end
    end

    // One burst: build the expected timeline, drive trigger/abort, drain queues.
    // abort_at>0 aborts in that cycle; trigger is also pulsed in cycles tf..tt.
    task automatic run_burst(input int l, input int n, input int g, input int abort_at,
                             input int tf, input int tt, input bit from_reset,
                             output int od, output int ow);
        int s, e, idle, done_rel, end_rel;
        wq.delete();
        gq.delete();
        dq.delete();
        for (int r = 0; r < MAXR; r++) begin
            exp_busy[r] = 1'b0;
            exp_ge[r]   = 1'b0;
        end
        done_rel = 1;
        if (l == 0 || n == 0) begin
            exp_busy[1] = 1'b1;
            dq.push_back(1);
        end else begin
            s = 1;
            for (int k = 0; k < n; k++) begin
                for (int j = 0; j < l; j++) begin
                    if (abort_at == 0 || s + j <= abort_at) begin
                        wr_t w;
                        w.rel = s + j;
                        w.st  = (j == 0);
                        w.la  = (j == l - 1);
                        w.idx = k;
                        wq.push_back(w);
                        if (s + j < MAXR) exp_busy[s + j] = 1'b1;
                    end
                end
                e = s + l;
                if (k == n - 1) begin
                    done_rel = e;
                    if (abort_at == 0 || e <= abort_at) begin
                        dq.push_back(e);
                        if (e < MAXR) exp_busy[e] = 1'b1;
                    end
                end else begin
                    idle = (g == 0) ? 3 : g + 4;
                    if (abort_at == 0 || e <= abort_at) gq.push_back(e);
                    for (int r = e; r < e + idle; r++) begin
                        if ((abort_at == 0 || r <= abort_at) && r < MAXR) begin
                            exp_busy[r] = 1'b1;
                            exp_ge[r]   = 1'b1;
                        end
                    end
                    s = e + idle;
                end
            end
        end
        end_rel = (abort_at > 0) ? abort_at + 6 : done_rel + 4;

        gap_val         = g;
        waveform_length = LEN_W'(l);
        num_waveforms   = NWFM_W'(n);
        obs_done_rel    = -1;
        obs_writes      = 0;
        if (from_reset) rst_n = 1'b1;
        else begin
            @(posedge clk);
            #1;
        end
        t0      = cyc;
        mon_on  = 1'b1;
        trigger = 1'b1;
        abort   = 1'b0;
        for (int r = 1; r <= end_rel; r++) begin
            @(posedge clk);
            #1;
            trigger = (r >= tf && r <= tt);
            abort   = (abort_at > 0 && r == abort_at);
            if (abort_at > 0 && r == abort_at + 1) check("index_after_abort", 64'(wfm_index), 64'd0);
        end
        trigger = 1'b0;
        abort   = 1'b0;
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        check("writes_left", 64'(wq.size()), 64'd0);
        check("gap_inits_left", 64'(gq.size()), 64'd0);
        check("dones_left", 64'(dq.size()), 64'd0);
        od = obs_done_rel;
        ow = obs_writes;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int od, ow;

        vecs[0] = '{4, 3, 5, 31, 12};
        vecs[1] = '{1, 2, 0,  6,  2};
        vecs[2] = '{0, 3, 2,  1,  0};
        vecs[3] = '{5, 0, 1,  1,  0};
        vecs[4] = '{2, 2, 1, 10,  4};
        vecs[5] = '{2, 3, 0, 13,  6};
        vecs[6] = '{1, 1, 0,  2,  1};
        vecs[7] = '{3, 2, 2, 13,  6};

        rst_n           = 1'b0;
        trigger         = 1'b0;
        abort           = 1'b0;
        waveform_length = '0;
        num_waveforms   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({gap_init, gap_enable, wfm_write_en, wfm_start, wfm_last, wfm_index, busy, done}), 64'd0);
        rst_n = 1'b1;

        // Table of bursts with hand-derived done cycle and write count
        foreach (vecs[i]) begin
            run_burst(vecs[i].l, vecs[i].n, vecs[i].g, 0, 0, -1, 1'b0, od, ow);
            check($sformatf("vec%0d_done", i), 64'(od), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d_writes", i), 64'(ow), 64'(vecs[i].exp_writes));
        end

        // Triggers throughout a busy burst are ignored
        run_burst(2, 2, 1, 0, 2, 9, 1'b0, od, ow);
        check("busy_trig_done", 64'(od), 64'd10);
        check("busy_trig_writes", 64'(ow), 64'd4);

        // A trigger in the DONE cycle is ignored
        run_burst(2, 2, 1, 0, 10, 10, 1'b0, od, ow);
        check("done_trig_done", 64'(od), 64'd10);
        check("done_trig_writes", 64'(ow), 64'd4);

        // Abort (with a simultaneous trigger) during the gap after waveform 1
        run_burst(3, 3, 4, 18, 18, 18, 1'b0, od, ow);
        check("abort_no_done", 64'(od), 64'hFFFF_FFFF_FFFF_FFFF);
        check("abort_writes", 64'(ow), 64'd6);
        run_burst(1, 1, 0, 0, 0, -1, 1'b0, od, ow);
        check("after_abort_done", 64'(od), 64'd2);

        // Asynchronous reset mid-acquisition, then trigger on the first edge after release
        waveform_length = LEN_W'(8);
        num_waveforms   = NWFM_W'(1);
        @(posedge clk);
        #1;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_write_en", 64'(wfm_write_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({gap_init, gap_enable, wfm_write_en, wfm_start, wfm_last, wfm_index, busy, done}), 64'd0);
        @(posedge clk);
        #1;
        check("held_reset_outputs",
              64'({gap_init, gap_enable, wfm_write_en, wfm_start, wfm_last, wfm_index, busy, done}), 64'd0);
        run_burst(2, 2, 1, 0, 0, -1, 1'b1, od, ow);
        check("post_reset_done", 64'(od), 64'd10);
        check("post_reset_writes", 64'(ow), 64'd4);

`ifdef ADC_SEQ_OVERRUN_CNT_EN
        // 300 rejected triggers saturate the overrun counter; burst still completes
        run_burst(400, 1, 0, 0, 2, 301, 1'b0, od, ow);
        check("overrun_done", 64'(od), 64'd401);
        check("overrun_writes", 64'(ow), 64'd400);
        check("overrun_cnt", 64'(overrun_cnt), 64'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
